// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered ALU with valid/ready handshakes and an optional
//            iterative shift-add multiplier (enabled by `define ALU_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       opcode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);

  localparam logic [5:0] c_OP_ADD   = 6'h00;
  localparam logic [5:0] c_OP_ADC   = 6'h01;
  localparam logic [5:0] c_OP_SUB   = 6'h02;
  localparam logic [5:0] c_OP_SBC   = 6'h03;
  localparam logic [5:0] c_OP_INC   = 6'h04;
  localparam logic [5:0] c_OP_DEC   = 6'h05;
  localparam logic [5:0] c_OP_NEG   = 6'h06;
  localparam logic [5:0] c_OP_AND   = 6'h08;
  localparam logic [5:0] c_OP_OR    = 6'h09;
  localparam logic [5:0] c_OP_XOR   = 6'h0A;
  localparam logic [5:0] c_OP_NOT   = 6'h0B;
  localparam logic [5:0] c_OP_LSL   = 6'h0C;
  localparam logic [5:0] c_OP_LSR   = 6'h0D;
  localparam logic [5:0] c_OP_ASR   = 6'h0E;
  localparam logic [5:0] c_OP_ROL   = 6'h0F;
  localparam logic [5:0] c_OP_ROR   = 6'h10;
  localparam logic [5:0] c_OP_CMP   = 6'h11;
  localparam logic [5:0] c_OP_SLT   = 6'h12;
  localparam logic [5:0] c_OP_SLTU  = 6'h13;
  localparam logic [5:0] c_OP_PASSA = 6'h14;
  localparam logic [5:0] c_OP_PASSB = 6'h15;
  localparam logic [5:0] c_OP_NOP   = 6'h3F;
`ifdef ALU_MUL_EN
  localparam logic [5:0] c_OP_MUL   = 6'h18;
  localparam logic [5:0] c_OP_MULH  = 6'h19;
`endif

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW:0]     c_W   = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0] w_x, w_y;
  logic             w_ci, w_sub;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [SHW-1:0]   w_sh;
  logic [SHW:0]     w_rsh;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_ill, w_mul;
  logic             w_idle, w_busy, w_accept;

  logic [WIDTH-1:0] r_result;
  logic             r_out_valid, r_zero, r_sign, r_carry, r_ovf, r_ill;

  // Shared adder: subtraction forms route through here so borrow lands on bit WIDTH
  always_comb begin
    w_x   = a;
    w_y   = b;
    w_ci  = 1'b0;
    w_sub = 1'b0;
    case (opcode)
      c_OP_ADC:           w_ci = carry_in;
      c_OP_SUB, c_OP_CMP: w_sub = 1'b1;
      c_OP_SBC: begin
        w_sub = 1'b1;
        w_ci  = carry_in;
      end
      c_OP_INC:           w_y = c_ONE;
      c_OP_DEC: begin
        w_sub = 1'b1;
        w_y   = c_ONE;
      end
      c_OP_NEG: begin
        w_sub = 1'b1;
        w_x   = '0;
        w_y   = a;
      end
      default: ;
    endcase
  end

  assign w_sum = w_sub ? ({1'b0, w_x} - {1'b0, w_y} - {{WIDTH{1'b0}}, w_ci})
                       : ({1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci});
  assign w_ovf = w_sub ? ((w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]))
                       : ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]));

  assign w_sh  = b[SHW-1:0];
  assign w_rsh = c_W - {1'b0, w_sh};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    w_mul = 1'b0;
    case (opcode)
      c_OP_ADD, c_OP_ADC, c_OP_SUB, c_OP_SBC,
      c_OP_INC, c_OP_DEC, c_OP_NEG: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      c_OP_AND:   w_res = a & b;
      c_OP_OR:    w_res = a | b;
      c_OP_XOR:   w_res = a ^ b;
      c_OP_NOT:   w_res = ~a;
      c_OP_LSL:   w_res = a << w_sh;
      c_OP_LSR:   w_res = a >> w_sh;
      c_OP_ASR:   w_res = $unsigned($signed(a) >>> w_sh);
      // A right shift by WIDTH yields 0, so rotate-by-0 collapses to a
      c_OP_ROL:   w_res = (a << w_sh) | (a >> w_rsh);
      c_OP_ROR:   w_res = (a >> w_sh) | (a << w_rsh);
      c_OP_CMP: begin
        w_c = w_sum[WIDTH];
        w_v = w_ovf;
      end
      c_OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      c_OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      c_OP_PASSA: w_res = a;
      c_OP_PASSB: w_res = b;
      c_OP_NOP:   ;
`ifdef ALU_MUL_EN
      c_OP_MUL, c_OP_MULH: w_mul = 1'b1;
`endif
      default:    w_ill = 1'b1;
    endcase
  end

  assign in_ready = w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_MUL  = 1'b1;
  localparam logic [SHW:0] c_CNT_ONE = {{SHW{1'b0}}, 1'b1};

  logic [0:0]         r_state, w_state_nxt;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_mulh;
  logic [WIDTH:0]     w_hi_sum;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_mul_res;
  logic               w_mul_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept && w_mul) w_state_nxt = c_ST_MUL;
      c_ST_MUL:  if (w_mul_done)        w_state_nxt = c_ST_IDLE;
      default:                          w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_idle = (r_state == c_ST_IDLE);
    w_busy = (r_state == c_ST_MUL);
  end

  // Accumulator starts as {0, b}; each step conditionally adds a to the high half and shifts right
  assign w_hi_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_done = (r_state == c_ST_MUL) && (r_cnt == c_W);
  assign w_mul_res  = r_mulh ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
  assign w_mul_c    = !r_mulh && (r_acc[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mulh  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept && w_mul) begin
      r_acc   <= {{WIDTH{1'b0}}, b};
      r_mcand <= a;
      r_mulh  <= (opcode == c_OP_MULH);
      r_cnt   <= '0;
    end else if ((r_state == c_ST_MUL) && !w_mul_done) begin
      r_acc   <= {w_hi_sum, r_acc[WIDTH-1:1]};
      r_cnt   <= r_cnt + c_CNT_ONE;
    end
  end
`else
  assign w_idle = 1'b1;
  assign w_busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
    end else if (w_accept && !w_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_zero      <= (w_res == '0);
      r_sign      <= w_res[WIDTH-1];
      r_carry     <= w_c;
      r_ovf       <= w_v;
      r_ill       <= w_ill;
`ifdef ALU_MUL_EN
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_res;
      r_zero      <= (w_mul_res == '0);
      r_sign      <= w_mul_res[WIDTH-1];
      r_carry     <= w_mul_c;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign sign      = r_sign;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign illegal   = r_ill;
  assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Scoreboard bench for alu_pipe; MUL cases built when ALU_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [5:0]  opcode;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, sign, carry, overflow, illegal, busy;

  int errors = 0;
  int checks = 0;
  // Each entry: {result[31:0], zero, sign, carry, overflow, illegal}
  logic [36:0] sb[$];

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .sign(sign), .carry(carry), .overflow(overflow),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive an op, wait for acceptance, queue its expected response.
  task automatic issue(input logic [5:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input logic ci, input logic [31:0] er, input logic [4:0] ef,
                       output int waits);
    logic rdy;
    waits    = 0;
    rdy      = 1'b0;
    in_valid = 1'b1;
    opcode   = op;
    a        = aa;
    b        = bb;
    carry_in = ci;
    while (!rdy && waits < 200) begin
      @(negedge clk);
      rdy = in_ready;
      waits++;
      @(posedge clk);
    end
    if (rdy) sb.push_back({er, ef});
    else begin
      errors++;
      checks++;
      $display("FAIL accept_timeout op=0x%02h waited=%0d", op, waits);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic b2b(input string name, input logic [5:0] op, input logic [31:0] aa,
                     input logic [31:0] bb, input logic ci, input logic [31:0] er,
                     input logic [4:0] ef);
    int w;
    issue(op, aa, bb, ci, er, ef, w);
    chk({name, "_accept_wait"}, 32'(w), 32'd1);
    chk({name, "_latency1"}, {31'b0, out_valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_result actual=0x%08h required=none", result);
      end else begin
        e = sb.pop_front();
        chk("result", result, e[36:5]);
        chk("flags_zscvi", {27'b0, zero, sign, carry, overflow, illegal}, {27'b0, e[4:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    carry_in  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {26'b0, zero, sign, carry, overflow, illegal, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops; flags column is {zero,sign,carry,overflow,illegal}
    b2b("add_wrap",  6'h00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 5'b10100);
    b2b("sub_ovf",   6'h02, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 5'b00010);
    b2b("sub_borrow",6'h02, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 5'b01100);
    b2b("adc",       6'h01, 32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 5'b00000);
    b2b("sbc",       6'h03, 32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 5'b00000);
    b2b("inc_ovf",   6'h04, 32'h7FFFFFFF, 32'h00000000, 1'b0, 32'h80000000, 5'b01010);
    b2b("dec_zero",  6'h05, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 5'b01100);
    b2b("neg_one",   6'h06, 32'h00000001, 32'h00000000, 1'b0, 32'hFFFFFFFF, 5'b01100);
    b2b("and",       6'h08, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 5'b01000);
    b2b("or",        6'h09, 32'h0000000F, 32'h000000F0, 1'b0, 32'h000000FF, 5'b00000);
    b2b("xor",       6'h0A, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 32'h55555555, 5'b00000);
    b2b("not",       6'h0B, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 5'b10000);
    b2b("lsl31",     6'h0C, 32'h00000001, 32'h0000001F, 1'b0, 32'h80000000, 5'b01000);
    b2b("lsr4",      6'h0D, 32'h80000000, 32'h00000004, 1'b0, 32'h08000000, 5'b00000);
    b2b("asr4",      6'h0E, 32'h80000000, 32'h00000004, 1'b0, 32'hF8000000, 5'b01000);
    b2b("ror1",      6'h10, 32'h00000001, 32'h00000001, 1'b0, 32'h80000000, 5'b01000);
    b2b("rol_by0",   6'h0F, 32'h12345678, 32'h00000020, 1'b0, 32'h12345678, 5'b00000);
    b2b("cmp_lt",    6'h11, 32'h00000003, 32'h00000005, 1'b0, 32'h00000000, 5'b10100);
    b2b("slt",       6'h12, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001, 5'b00000);
    b2b("sltu",      6'h13, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 5'b10000);
    b2b("passb",     6'h15, 32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 5'b01000);
    b2b("illegal20", 6'h20, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000, 5'b10001);
`ifndef ALU_MUL_EN
    b2b("mul_off",   6'h18, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 5'b10001);
`endif

    @(posedge clk); #1;
    chk("consume_clear", {31'b0, out_valid}, 32'd0);

    out_ready = 1'b0;
    issue(6'h0F, 32'h80000001, 32'h00000001, 1'b0, 32'h00000003, 5'b00000, w);
    chk("rol_accept_wait", 32'(w), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_result", result, 32'h00000003);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    issue(6'h00, 32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 5'b00000, w);
    chk("release_same_edge", 32'(w), 32'd1);

`ifdef ALU_MUL_EN
    issue(6'h18, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 5'b10100, w);
    chk("mul_busy", {31'b0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      chk("mul_in_ready_low", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("mul_latency", 32'(n), 32'd33);

    issue(6'h19, 32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 5'b00000, w);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mulh_latency", 32'(n), 32'd33);

    issue(6'h18, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'hFFFFFFFE, 5'b01100, w);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mul2_latency", 32'(n), 32'd33);

    // Aborted multiply: its queued expectation is withdrawn
    issue(6'h18, 32'h00000007, 32'h00000009, 1'b0, 32'h0000003F, 5'b00000, w);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {26'b0, zero, sign, carry, overflow, illegal, busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", {31'b0, seen}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
